clkdiv_ctrl: RTL
================

CLKDIV_CTRL -- requirements
Module: clkdiv_ctrl

Interface
REQ-001 The block SHALL have parameter W, default 16, meaning the bit width of the half-period count.
REQ-002 The block SHALL have parameter DEF_HALF, default 10, meaning the half-period loaded at reset, in I_CLK cycles.
REQ-003 The block SHALL have port I_CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-005 The block SHALL have port en, input, 1 bit: run request for the divided clock.
REQ-006 The block SHALL have port req, input, 2 bits: per-requester reconfiguration request, held until granted.
REQ-007 The block SHALL have ports half0 and half1, input, W bits each: the requested half-period for requester 0 and requester 1.
REQ-008 The block SHALL have port gnt, output, 2 bits: a one-cycle, one-hot grant that accepts that requester's half value.
REQ-009 The block SHALL have port O_CLK, output, 1 bit: the divided clock, registered.
REQ-010 The block SHALL have port tick, output, 1 bit: a one-cycle pulse in the cycle O_CLK rises.
REQ-011 The block SHALL have port busy, output, 1 bit: high while an accepted value is pending.
REQ-012 The block SHALL have port cur_half, output, W bits: the half-period currently in effect.

Function
REQ-013 The FSM SHALL have the states STOP, RUN and PEND.
REQ-014 In RUN and PEND, cnt SHALL count 0..cur_half-1; at cnt==cur_half-1, O_CLK toggles and cnt returns to 0.
REQ-015 tick SHALL be 1 in the cycle O_CLK is registered 0->1, and 0 otherwise.
REQ-016 In STOP, O_CLK SHALL be 0 and cnt SHALL be 0; en=1 moves STOP->RUN, and the first toggle comes cur_half cycles later.
REQ-017 Arbitration SHALL be round-robin with a last-grant pointer; with both req bits high, the requester not granted last wins; after reset, requester 0 wins.
REQ-018 A grant SHALL be issued only in STOP or RUN, never in PEND, and never in the cycle after a grant; gnt is registered, one cycle after req is sampled.
REQ-019 A granted value of 0 SHALL be stored as 1.
REQ-020 A grant in STOP SHALL load cur_half immediately, and the state stays STOP.
REQ-021 A grant in RUN SHALL store the value in a pending register and move to PEND, with busy=1.
REQ-022 PEND SHALL apply pending->cur_half only on the toggle where O_CLK goes 1->0 (a full-period boundary), then busy=0 and the state returns to RUN; no partial period at the new ratio is ever produced.
REQ-023 en=0 in RUN or PEND SHALL stop at the next 1->0 toggle: state STOP, O_CLK=0; a pending value is applied at that same boundary.
REQ-024 If en returns to 1 before that boundary, the stop SHALL be cancelled.
REQ-025 A req deasserted before its grant SHALL be dropped with no side effect.
REQ-026 If a grant and a 1->0 boundary coincide in RUN, the new value SHALL become pending and take effect at the following boundary.

Reset
REQ-027 While rst_n=0, the block SHALL hold state=STOP, cnt=0, O_CLK=0, tick=0, gnt=00, busy=0, cur_half=DEF_HALF, pending=DEF_HALF, and the RR pointer favouring requester 0.
REQ-028 Reset asserted mid-operation SHALL abort any pending value immediately; the first output after release is from STOP.

Structure
REQ-029 The FSM state encoding and the DEF_HALF default SHALL reside in the shared package clkdiv_pkg.
REQ-030 The round-robin arbiter SHALL be the sub-module rr_arb2 (inputs req[1:0] and enable; output one-hot gnt[1:0] plus pointer update).
REQ-031 The counter and toggle logic SHALL stay inline in clkdiv_ctrl.

Verification
REQ-032 Reset, then en=1 with DEF_HALF=10 -> O_CLK period of 20 cycles, tick every 20 cycles, the first rise 10 cycles after RUN is entered.
REQ-033 In RUN with half=10, req=01 and half0=3 -> gnt=01 for 1 cycle, busy=1, the current period completes at 10/10, then periods of 6 cycles follow and busy=0.
REQ-034 req=11 held, half0=4, half1=6 -> the first gnt goes to 01, the next gnt (after the boundary) goes to 10, and the effective half sequence is 4 then 6.
REQ-035 In STOP, req=10 with half1=0 -> cur_half=1; then en=1 -> O_CLK period of 2 cycles.
REQ-036 en dropped while O_CLK=1 with a value pending -> O_CLK falls on schedule, the state is STOP, and cur_half equals the pending value.
REQ-037 rst_n pulsed low for 1 cycle during PEND -> all outputs at their reset values asynchronously, and cur_half=DEF_HALF.

Source files
------------

// File: rtl/clkdiv_pkg.sv
// -----------------------------------------------------------------------------
// clkdiv_pkg
// Shared definitions for the programmable clock divider:
//   - state_e          : controller FSM encoding (STOP / RUN / PEND)
//   - CLKDIV_DEF_W     : default width of the half-period count
//   - CLKDIV_DEF_HALF  : default half-period loaded at reset
//   - rr_pick()        : two-way round-robin selection helper
// -----------------------------------------------------------------------------
package clkdiv_pkg;

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_e;

  localparam int CLKDIV_DEF_W    = 16;
  localparam int CLKDIV_DEF_HALF = 10;

  // Returns a one-hot winner. last=1 means requester 1 was granted last,
  // so on a tie requester 0 wins, and vice versa.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last);
    logic [1:0] win;
    case (req)
      2'b01:   win = 2'b01;
      2'b10:   win = 2'b10;
      2'b11:   win = last ? 2'b01 : 2'b10;
      default: win = 2'b00;
    endcase
    return win;
  endfunction

endpackage

// File: rtl/clkdiv_ctrl_if.sv
// -----------------------------------------------------------------------------
// clkdiv_ctrl_if
// Reconfiguration channel between the two requesters and the divider.
//   req[1:0]   : per-requester request, held until granted
//   half0/1    : requested half-period of requester 0 / 1
//   gnt[1:0]   : one-cycle one-hot grant
// Modports:
//   master : requester side (drives req/half, observes gnt)
//   slave  : arbiter side   (observes req/half, drives gnt)
// -----------------------------------------------------------------------------
interface clkdiv_ctrl_if #(
  parameter int W = clkdiv_pkg::CLKDIV_DEF_W
);
  logic [1:0]   req;
  logic [W-1:0] half0;
  logic [W-1:0] half1;
  logic [1:0]   gnt;

  modport master (output req, output half0, output half1, input gnt);
  modport slave  (input req, input half0, input half1, output gnt);
endinterface

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter with a last-grant pointer.
//   clk, rst_n : clock, asynchronous active-low reset
//   enable     : grants may be issued this cycle
//   bus        : slave side of the reconfiguration channel (req/half in,
//                registered one-hot gnt out)
//   win        : combinational winner for this cycle (what gnt will show next)
//   win_half   : half value of that winner, captured by the parent on the
//                same edge that registers gnt
// After reset the pointer favours requester 0.
// -----------------------------------------------------------------------------
module rr_arb2 import clkdiv_pkg::*; #(
  parameter int W = CLKDIV_DEF_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  clkdiv_ctrl_if.slave bus,
  output logic [1:0]   win,
  output logic [W-1:0] win_half
);

  logic [1:0] gnt_d, gnt_q;
  logic       last_d, last_q;   // 1: requester 1 was granted last

  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt_d    = enable ? rr_pick(bus.req, last_q) : 2'b00;
    last_d   = last_q;
    win_half = gnt_d[1] ? bus.half1 : bus.half0;
    if (gnt_d != 2'b00) begin
      last_d = gnt_d[1];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q  <= 2'b00;
      last_q <= 1'b1;
    end else begin
      gnt_q  <= gnt_d;
      last_q <= last_d;
    end
  end

  assign bus.gnt = gnt_q;
  assign win     = gnt_d;

endmodule

// File: rtl/clkdiv_ctrl.sv
// -----------------------------------------------------------------------------
// clkdiv_ctrl
// Programmable clock divider with glitch-free ratio changes.
// O_CLK has a period of 2*cur_half I_CLK cycles. Two requesters may ask for a
// new half-period; a round-robin arbiter grants one at a time. A new value
// takes effect only on an O_CLK falling toggle, so no short period is ever
// produced. Stopping also happens on a falling toggle.
// Ports:
//   I_CLK, rst_n  : clock, asynchronous active-low reset
//   en            : run request
//   req, half0/1  : reconfiguration requests and requested half-periods
//   gnt           : one-cycle one-hot grant (registered)
//   O_CLK         : divided clock (registered)
//   tick          : one-cycle pulse in the cycle O_CLK rises
//   busy          : an accepted value is waiting for its boundary
//   cur_half      : half-period currently in effect
// -----------------------------------------------------------------------------
module clkdiv_ctrl import clkdiv_pkg::*; #(
  parameter int W        = CLKDIV_DEF_W,
  parameter int DEF_HALF = CLKDIV_DEF_HALF
) (
  input  logic         I_CLK,
  input  logic         rst_n,
  input  logic         en,
  input  logic [1:0]   req,
  input  logic [W-1:0] half0,
  input  logic [W-1:0] half1,
  output logic [1:0]   gnt,
  output logic         O_CLK,
  output logic         tick,
  output logic         busy,
  output logic [W-1:0] cur_half
);

  clkdiv_ctrl_if #(.W(W)) u_cfg_if ();

  assign u_cfg_if.req   = req;
  assign u_cfg_if.half0 = half0;
  assign u_cfg_if.half1 = half1;
  assign gnt            = u_cfg_if.gnt;

  state_e       state_d, state_q;
  logic [W-1:0] cnt_d, cnt_q;
  logic         o_clk_d, o_clk_q;
  logic         tick_d, tick_q;
  logic         busy_d, busy_q;
  logic [W-1:0] cur_half_d, cur_half_q;
  logic [W-1:0] pend_half_d, pend_half_q;

  logic         arb_en;
  logic [1:0]   arb_win;
  logic [W-1:0] arb_half;
  logic [W-1:0] new_half;
  logic         grant;
  logic         wrap;
  logic         fall;

  // No grant while a value is pending, nor in the cycle gnt is showing.
  assign arb_en = (state_q != ST_PEND) && (u_cfg_if.gnt == 2'b00);

  rr_arb2 #(.W(W)) u_arb (
    .clk      (I_CLK),
    .rst_n    (rst_n),
    .enable   (arb_en),
    .bus      (u_cfg_if.slave),
    .win      (arb_win),
    .win_half (arb_half)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    o_clk_d     = o_clk_q;
    tick_d      = 1'b0;
    busy_d      = busy_q;
    cur_half_d  = cur_half_q;
    pend_half_d = pend_half_q;

    grant    = (arb_win != 2'b00);
    // A half-period of 0 would never wrap; treat it as 1.
    new_half = (arb_half == '0) ? W'(1) : arb_half;
    wrap     = (cnt_q == cur_half_q - W'(1));
    fall     = 1'b0;

    case (state_q)
      ST_STOP: begin
        cnt_d   = '0;
        o_clk_d = 1'b0;
        if (grant) begin
          cur_half_d = new_half;
        end
        if (en) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN, ST_PEND: begin
        fall  = wrap && o_clk_q;
        cnt_d = wrap ? '0 : cnt_q + W'(1);
        if (wrap) begin
          o_clk_d = ~o_clk_q;
          tick_d  = ~o_clk_q;
        end

        // Full-period boundary: the only place a pending value is applied.
        if (fall && (state_q == ST_PEND)) begin
          cur_half_d = pend_half_q;
          busy_d     = 1'b0;
          state_d    = ST_RUN;
        end

        // Grants only reach here in RUN (arb_en blocks PEND). A grant landing
        // on a boundary waits for the next one, unless the divider stops at
        // this boundary, in which case it loads directly as it would in STOP.
        if (grant) begin
          if (fall && !en) begin
            cur_half_d = new_half;
          end else begin
            pend_half_d = new_half;
            busy_d      = 1'b1;
            state_d     = ST_PEND;
          end
        end

        // en is sampled only at the boundary, so a brief drop is cancelled.
        if (fall && !en) begin
          state_d = ST_STOP;
          busy_d  = 1'b0;
        end
      end

      default: begin
        state_d = ST_STOP;
        cnt_d   = '0;
        o_clk_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge I_CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_STOP;
      cnt_q       <= '0;
      o_clk_q     <= 1'b0;
      tick_q      <= 1'b0;
      busy_q      <= 1'b0;
      cur_half_q  <= W'(DEF_HALF);
      pend_half_q <= W'(DEF_HALF);
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      o_clk_q     <= o_clk_d;
      tick_q      <= tick_d;
      busy_q      <= busy_d;
      cur_half_q  <= cur_half_d;
      pend_half_q <= pend_half_d;
    end
  end

  assign O_CLK    = o_clk_q;
  assign tick     = tick_q;
  assign busy     = busy_q;
  assign cur_half = cur_half_q;

endmodule
